// File: rtl/alu_pkg.sv
// alu_pkg: opcode, FSM state encodings and div-by-zero fill shared by the ALU scheduler
package alu_pkg;
  typedef enum logic [2:0] {OC_ADD, OC_SUB, OC_MUL, OC_DIV, OC_NOTA, OC_XOR, OC_OR, OC_AND} oc_e;
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;
  localparam logic DZ_FILL_BIT = 1'b1;
endpackage

// File: rtl/aluSeq.sv
// aluSeq: combinational ALU, results wrap to W bits, divide is unsigned truncating
module aluSeq import alu_pkg::*; #(
  parameter int W = 16
) (
  input  oc_e          i_oc,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_y
);
  // opcode decode; a zero divisor is handled by the caller
  always_comb begin
    o_y = '0;
    case (i_oc)
      OC_ADD:  o_y = i_a + i_b;
      OC_SUB:  o_y = i_a - i_b;
      OC_MUL:  o_y = i_a * i_b;
      OC_DIV:  o_y = i_a / i_b;
      OC_NOTA: o_y = ~i_a;
      OC_XOR:  o_y = i_a ^ i_b;
      OC_OR:   o_y = i_a | i_b;
      OC_AND:  o_y = i_a & i_b;
      default: o_y = '0;
    endcase
  end
endmodule

// File: rtl/alu_rr_arb.sv
// alu_rr_arb: 2-way round-robin arbiter; the pointer only moves when a grant is taken
module alu_rr_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  logic       i_upd,
  output logic [1:0] o_gnt
);
  logic r_last;
  // on contention, favour whichever requester was not served last
  always_comb o_gnt = (i_req == 2'b11) ? (r_last ? 2'b01 : 2'b10) : i_req;
  // remember the served requester; reset makes requester 0 the favoured one
  always_ff @(posedge clk) r_last <= rst ? 1'b1 : (i_upd ? o_gnt[1] : r_last);
endmodule

// File: rtl/alu_sched.sv
// alu_sched: two-requester ALU scheduler, one operation in flight, IDLE/EXEC/DONE
module alu_sched import alu_pkg::*; #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [2:0]            req0_oc,
  input  logic [DATA_WIDTH-1:0] req0_a,
  input  logic [DATA_WIDTH-1:0] req0_b,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [2:0]            req1_oc,
  input  logic [DATA_WIDTH-1:0] req1_a,
  input  logic [DATA_WIDTH-1:0] req1_b,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic                  res_id,
  output logic                  res_dz,
  output logic [CNT_WIDTH-1:0]  op_count
);
  state_e                r_state, w_next;
  logic [1:0]            w_gnt;
  logic                  w_hs, w_dz, r_src, r_id, r_dz;
  oc_e                   r_oc;
  logic [DATA_WIDTH-1:0] r_a, r_b, w_alu, r_data;
  logic [CNT_WIDTH-1:0]  r_cnt;

  alu_rr_arb u_arb (
    .clk   (clk),
    .rst   (rst),
    .i_req ({req1_valid, req0_valid}),
    .i_upd (w_hs),
    .o_gnt (w_gnt)
  );

  aluSeq #(.W(DATA_WIDTH)) u_alu (
    .i_oc (r_oc),
    .i_a  (r_a),
    .i_b  (r_b),
    .o_y  (w_alu)
  );

  assign w_dz     = (r_oc == OC_DIV) && (r_b == '0);
  assign res_data = r_data;
  assign res_id   = r_id;
  assign res_dz   = r_dz;
  assign op_count = r_cnt;

  // state register
  always_ff @(posedge clk) r_state <= rst ? IDLE : w_next;

  // next state and handshake outputs, all forced low while reset is held
  always_comb begin
    w_next     = r_state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    res_valid  = 1'b0;
    w_hs       = 1'b0;
    case (r_state)
      IDLE: begin
        req0_ready = !rst && w_gnt[0];
        req1_ready = !rst && w_gnt[1];
        w_hs       = req0_ready || req1_ready;
        w_next     = w_hs ? EXEC : IDLE;
      end
      EXEC: w_next = DONE;
      DONE: begin
        res_valid = !rst;
        w_next    = res_ready ? IDLE : DONE;
      end
      default: w_next = IDLE;
    endcase
  end

  // operand capture on grant, result capture in EXEC, completion count on result handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      r_src  <= 1'b0;
      r_data <= '0;
      r_id   <= 1'b0;
      r_dz   <= 1'b0;
      r_cnt  <= '0;
    end else begin
      if (w_hs) begin
        r_src <= w_gnt[1];
        r_oc  <= oc_e'(w_gnt[1] ? req1_oc : req0_oc);
        r_a   <= w_gnt[1] ? req1_a : req0_a;
        r_b   <= w_gnt[1] ? req1_b : req0_b;
      end
      if (r_state == EXEC) begin
        r_data <= w_dz ? {DATA_WIDTH{DZ_FILL_BIT}} : w_alu;
        r_dz   <= w_dz;
        r_id   <= r_src;
      end
      if (res_valid && res_ready) r_cnt <= r_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_alu_sched.sv
// tb_alu_sched: transaction-level model check of alu_sched plus directed literal cases
module tb_alu_sched;
  logic        clk = 1'b0, rst = 1'b1;
  logic        req0_valid = 0, req1_valid = 0, res_ready = 1;
  logic [2:0]  req0_oc = 0, req1_oc = 0;
  logic [15:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic        req0_ready, req1_ready, res_valid, res_id, res_dz;
  logic [15:0] res_data, op_count;
  logic        s_r0, s_r1, s_v, s_id, s_dz;
  logic [15:0] s_data;
  logic [1:0]  s_cnt;

  always #5 clk = ~clk;

  alu_sched #(.DATA_WIDTH(16), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_oc(req0_oc), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_oc(req1_oc), .req1_a(req1_a), .req1_b(req1_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_id(res_id), .res_dz(res_dz),
    .op_count(op_count)
  );

  alu_sched #(.DATA_WIDTH(16), .CNT_WIDTH(2)) dut_small (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(s_r0), .req0_oc(req0_oc), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(s_r1), .req1_oc(req1_oc), .req1_a(req1_a), .req1_b(req1_b),
    .res_valid(s_v), .res_ready(res_ready), .res_data(s_data), .res_id(s_id), .res_dz(s_dz),
    .op_count(s_cnt)
  );

  int n_chk = 0, n_pass = 0, cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic tmo(input string nm);
    n_chk++;
    $display("FAIL %s: timed out waiting (cycle %0d)", nm, cyc);
  endtask

  function automatic logic [16:0] ref_op(input logic [2:0] oc, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r;
    logic dz;
    dz = 1'b0;
    case (oc)
      3'd0: r = a + b;
      3'd1: r = a - b;
      3'd2: r = a * b;
      3'd3: if (b == 0) begin r = 16'hFFFF; dz = 1'b1; end else r = a / b;
      3'd4: r = ~a;
      3'd5: r = a ^ b;
      3'd6: r = a | b;
      default: r = a & b;
    endcase
    return {dz, r};
  endfunction

  // model state: at most one outstanding transaction
  logic        m_busy = 0, m_last = 1, m_id = 0, m_dz = 0;
  logic [15:0] m_data = 0, m_cnt = 0;
  int          m_h = 0;

  always @(negedge clk) begin
    logic g0, g1, exp_v;
    cyc++;
    if (rst) begin
      chk("rst_res_valid", res_valid, 0);
      chk("rst_readys", {req1_ready, req0_ready}, 0);
      m_busy = 0; m_cnt = 0; m_last = 1;
    end else begin
      exp_v = m_busy && (cyc >= m_h + 2);
      chk("op_count", op_count, m_cnt);
      chk("op_count_wrap", s_cnt, m_cnt[1:0]);
      chk("res_valid", res_valid, exp_v);
      if (exp_v && res_valid) begin
        chk("res_data", res_data, m_data);
        chk("res_id", res_id, m_id);
        chk("res_dz", res_dz, m_dz);
      end
      g0 = !m_busy && req0_valid && (!req1_valid || m_last);
      g1 = !m_busy && req1_valid && (!req0_valid || !m_last);
      chk("readys", {req1_ready, req0_ready}, {g1, g0});
      if (exp_v && res_ready) begin m_busy = 0; m_cnt++; end
      if (g0 || g1) begin
        m_busy = 1; m_h = cyc; m_last = g1; m_id = g1;
        {m_dz, m_data} = g1 ? ref_op(req1_oc, req1_a, req1_b) : ref_op(req0_oc, req0_a, req0_b);
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1 rst = 1;
    @(posedge clk); @(posedge clk); #1 rst = 0;
  endtask

  task automatic do_op(input bit id, input logic [2:0] oc, input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] d, output logic rid, output logic dz, output int lat);
    bit ok;
    d = 'x; rid = 'x; dz = 'x; lat = -1; ok = 0;
    @(posedge clk); #1;
    if (id) begin req1_valid = 1; req1_oc = oc; req1_a = a; req1_b = b; end
    else begin req0_valid = 1; req0_oc = oc; req0_a = a; req0_b = b; end
    for (int k = 0; k < 10 && !ok; k++) begin
      @(negedge clk);
      ok = id ? req1_ready : req0_ready;
    end
    if (!ok) begin tmo("grant"); req0_valid = 0; req1_valid = 0; return; end
    @(posedge clk); #1 req0_valid = 0; req1_valid = 0;
    for (int l = 1; l <= 10; l++) begin
      @(negedge clk);
      if (res_valid) begin lat = l; d = res_data; rid = res_id; dz = res_dz; return; end
    end
    tmo("result");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] d;
    logic rid, dz;
    int lat;
    int grants[$];
    logic [15:0] results[$];
    do_reset();
    @(negedge clk);
    chk("reset_op_count", op_count, 0);
    // add 3+4 from requester 0
    do_op(0, 3'd0, 16'd3, 16'd4, d, rid, dz, lat);
    chk("add_data", d, 16'd7);
    chk("add_id", rid, 0);
    chk("add_latency", lat, 2);
    @(posedge clk); @(negedge clk);
    chk("add_op_count", op_count, 1);
    // both requesters valid every cycle: round-robin from reset
    do_reset();
    @(posedge clk); #1;
    req0_valid = 1; req0_oc = 3'd2; req0_a = 16'h0100; req0_b = 16'h0100;
    req1_valid = 1; req1_oc = 3'd1; req1_a = 16'h0000; req1_b = 16'h0001;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (req0_ready) grants.push_back(0);
      else if (req1_ready) grants.push_back(1);
      if (res_valid && res_ready) results.push_back(res_data);
    end
    @(posedge clk); #1 req0_valid = 0; req1_valid = 0;
    chk("rr_grants", grants.size(), 4);
    chk("rr_results", results.size(), 4);
    if (grants.size() >= 3 && results.size() >= 3) begin
      chk("rr_g0", grants[0], 0);
      chk("rr_g1", grants[1], 1);
      chk("rr_g2", grants[2], 0);
      chk("rr_mul", results[0], 16'h0000);
      chk("rr_sub", results[1], 16'hFFFF);
      chk("rr_mul2", results[2], 16'h0000);
    end
    // divide by zero, then a normal divide
    do_op(1, 3'd3, 16'd10, 16'd0, d, rid, dz, lat);
    chk("div0_data", d, 16'hFFFF);
    chk("div0_dz", dz, 1);
    chk("div0_id", rid, 1);
    do_op(1, 3'd3, 16'd10, 16'd3, d, rid, dz, lat);
    chk("div_data", d, 16'd3);
    chk("div_dz", dz, 0);
    // consumer stalls for 5 cycles in DONE
    @(posedge clk); #1 res_ready = 0;
    do_op(0, 3'd5, 16'h00FF, 16'h0F0F, d, rid, dz, lat);
    chk("hold_data0", d, 16'h0FF0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1 req0_valid = 1; req1_valid = 1;
      @(negedge clk);
      chk("hold_valid", res_valid, 1);
      chk("hold_data", res_data, 16'h0FF0);
      chk("hold_readys", {req1_ready, req0_ready}, 0);
      chk("hold_count", op_count, 6);
    end
    @(posedge clk); #1 req0_valid = 0; req1_valid = 0; res_ready = 1;
    @(posedge clk); @(negedge clk);
    chk("release_count", op_count, 7);
    // reset during EXEC
    @(posedge clk); #1 req0_valid = 1; req0_oc = 3'd0; req0_a = 16'd1; req0_b = 16'd1;
    @(negedge clk);
    chk("exec_grant", req0_ready, 1);
    @(posedge clk); #1 req0_valid = 0; rst = 1;
    @(posedge clk); #1 rst = 0; req0_valid = 1; req1_valid = 1;
    @(negedge clk);
    chk("rst_exec_valid", res_valid, 0);
    chk("rst_exec_count", op_count, 0);
    chk("rst_exec_grant", {req1_ready, req0_ready}, 2'b01);
    @(posedge clk); #1 req0_valid = 0; req1_valid = 0;
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      rst        = ($urandom_range(0, 299) == 0);
      req0_valid = ($urandom_range(0, 99) < 50);
      req1_valid = ($urandom_range(0, 99) < 50);
      req0_oc    = 3'($urandom_range(0, 7));
      req1_oc    = 3'($urandom_range(0, 7));
      req0_a     = 16'($urandom);
      req1_a     = 16'($urandom);
      req0_b     = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
      req1_b     = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(0, 300));
      res_ready  = ($urandom_range(0, 99) < 70);
    end
    @(posedge clk); #1 rst = 0; req0_valid = 0; req1_valid = 0; res_ready = 1;
    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
